// File: rtl/sum3_rr_scheduler.sv
// Two-requester round-robin front end for one registered f = a + b + (c ? d : e) datapath.
// Results are returned in order on a single valid/ready port, tagged with the requester id.
module sum3_rr_scheduler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_c,
  input  logic [WIDTH-1:0] req0_d,
  input  logic [WIDTH-1:0] req0_e,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_c,
  input  logic [WIDTH-1:0] req1_d,
  input  logic [WIDTH-1:0] req1_e,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_id,
  output logic             busy,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e           state_q, state_d;
  logic             prio_q;
  logic [WIDTH-1:0] a_q, b_q, d_q, e_q;
  logic             c_q, id_q;
  logic [WIDTH-1:0] f_q;
  logic             res_id_q;
  logic [15:0]      ops_q;

  logic grant_any, grant1, xfer, res_hs;

  // Contention is resolved by prio_q; a lone requester wins outright.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant1    = (req0_valid & req1_valid) ? prio_q : req1_valid;
    xfer      = (state_q == StIdle) & grant_any;
    res_hs    = (state_q == StHold) & res_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (xfer) state_d = StExec;
      StExec:  state_d = StHold;
      StHold:  if (res_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == StIdle) & grant_any & ~grant1;
    req1_ready = (state_q == StIdle) & grant1;
    res_valid  = (state_q == StHold);
    busy       = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      d_q      <= '0;
      e_q      <= '0;
      id_q     <= 1'b0;
      f_q      <= '0;
      res_id_q <= 1'b0;
      ops_q    <= 16'd0;
    end else begin
      if (xfer) begin
        a_q    <= grant1 ? req1_a : req0_a;
        b_q    <= grant1 ? req1_b : req0_b;
        c_q    <= grant1 ? req1_c : req0_c;
        d_q    <= grant1 ? req1_d : req0_d;
        e_q    <= grant1 ? req1_e : req0_e;
        id_q   <= grant1;
        prio_q <= ~grant1;
      end
      if (state_q == StExec) begin
        f_q      <= a_q + b_q + (c_q ? d_q : e_q);
        res_id_q <= id_q;
      end
      if (res_hs) begin
        ops_q <= ops_q + 16'd1;
      end
    end
  end

  assign res_f    = f_q;
  assign res_id   = res_id_q;
  assign ops_done = ops_q;

endmodule

// File: tb/tb_sum3_rr_scheduler.sv
// Bench for sum3_rr_scheduler: directed scenarios plus random traffic against a
// transaction-level reference model of arbitration order and result arithmetic.
module tb_sum3_rr_scheduler;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         vld  [2];
  logic [W-1:0] opa  [2];
  logic [W-1:0] opb  [2];
  logic         opc  [2];
  logic [W-1:0] opd  [2];
  logic [W-1:0] ope  [2];
  bit           keep [2];
  logic         res_ready;

  logic         req0_ready, req1_ready, res_valid, res_id, busy;
  logic [W-1:0] res_f;
  logic [15:0]  ops_done;

  sum3_rr_scheduler #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(vld[0]),
    .req0_ready(req0_ready),
    .req0_a    (opa[0]),
    .req0_b    (opb[0]),
    .req0_c    (opc[0]),
    .req0_d    (opd[0]),
    .req0_e    (ope[0]),
    .req1_valid(vld[1]),
    .req1_ready(req1_ready),
    .req1_a    (opa[1]),
    .req1_b    (opb[1]),
    .req1_c    (opc[1]),
    .req1_d    (opd[1]),
    .req1_e    (ope[1]),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_f     (res_f),
    .res_id    (res_id),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = free, 1 = computing, 2 = result offered.
  int           m_phase;
  bit           m_prio;
  logic [W-1:0] m_f, cap_f;
  bit           m_id, cap_id;
  logic [15:0]  m_ops;
  int           acc;
  int           cyc = 0;
  logic [W-1:0] obs_f;
  logic         obs_id;
  logic [W-1:0] srv_f[$];
  bit           srv_id[$];
  int           srv_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_f(input int id);
    int sa, sb, sd, se, s;
    sa = $signed(opa[id]);
    sb = $signed(opb[id]);
    sd = $signed(opd[id]);
    se = $signed(ope[id]);
    s  = sa + sb + (opc[id] ? sd : se);
    return s[W-1:0];
  endfunction

  function automatic int model_grant();
    if (m_phase != 0) return -1;
    if (vld[0] && vld[1]) return int'(m_prio);
    if (vld[0]) return 0;
    if (vld[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_prio  = 1'b0;
    m_f     = '0;
    m_id    = 1'b0;
    m_ops   = 16'd0;
    cap_f   = '0;
    cap_id  = 1'b0;
  endtask

  task automatic set_req(input int id, input int a, input int b, input bit c, input int d,
                         input int e);
    opa[id] = a[W-1:0];
    opb[id] = b[W-1:0];
    opc[id] = c;
    opd[id] = d[W-1:0];
    ope[id] = e[W-1:0];
    vld[id] = 1'b1;
  endtask

  task automatic rand_req(input int id);
    set_req(id, int'($urandom), int'($urandom), bit'($urandom_range(0, 1)), int'($urandom),
            int'($urandom));
  endtask

  task automatic tick();
    int g;
    #1;
    g = model_grant();
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    check("res_valid", res_valid, m_phase == 2);
    check("busy", busy, m_phase != 0);
    check("res_f", res_f, m_f);
    check("res_id", res_id, m_id);
    check("ops_done", ops_done, m_ops);
    obs_f  = res_f;
    obs_id = res_id;
    @(posedge clk);
    cyc++;
    acc = -1;
    case (m_phase)
      0: if (g >= 0) begin
        cap_f   = ref_f(g);
        cap_id  = g[0];
        m_prio  = ~g[0];
        m_phase = 1;
        acc     = g;
      end
      1: begin
        m_f     = cap_f;
        m_id    = cap_id;
        m_phase = 2;
      end
      default: if (res_ready) begin
        m_ops++;
        srv_f.push_back(obs_f);
        srv_id.push_back(obs_id);
        srv_cyc.push_back(cyc);
        m_phase = 0;
      end
    endcase
    #1;
    if (acc >= 0) begin
      if (keep[acc]) rand_req(acc);
      else vld[acc] = 1'b0;
    end
  endtask

  task automatic run_ops(input int n, input int budget);
    int target;
    target = srv_id.size() + n;
    for (int i = 0; i < budget && srv_id.size() < target; i++) tick();
    check("op_count_within_budget", srv_id.size(), target);
  endtask

  task automatic do_reset();
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res_f", res_f, 0);
    check("rst_res_id", res_id, 0);
    check("rst_ops_done", ops_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    logic [W-1:0] exp_f;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; keep[i] = 1'b0;
      opa[i] = '0; opb[i] = '0; opc[i] = 1'b0; opd[i] = '0; ope[i] = '0;
    end
    res_ready = 1'b1;
    #1;
    do_reset();

    // Single request, with explicit latency checks.
    set_req(0, -20, -22, 1'b1, -21, -28);
    #1;
    check("single_ready0", req0_ready, 1);
    tick();
    check("single_exec_no_valid", res_valid, 0);
    tick();
    #1;
    check("single_valid", res_valid, 1);
    check("single_f", res_f, 16'hFFC1);
    check("single_id", res_id, 0);
    check("single_busy", busy, 1);
    tick();
    #1;
    check("single_ops_done", ops_done, 1);
    check("single_idle", busy, 0);

    // Simultaneous requests from reset: requester 0 first.
    do_reset();
    set_req(0, 17786, -16683, 1'b0, -14903, 10);
    set_req(1, 535, 19891, 1'b1, 4200, 579);
    base = srv_id.size();
    run_ops(2, 20);
    check("simul_f0", srv_f[base], 16'h0459);
    check("simul_id0", srv_id[base], 0);
    check("simul_f1", srv_f[base+1], 16'h6032);
    check("simul_id1", srv_id[base+1], 1);
    #1;
    check("simul_ops_done", ops_done, 2);

    // Wrap-around of the sum.
    set_req(1, -32589, 23979, 1'b1, -7232, 23599);
    base = srv_id.size();
    run_ops(1, 10);
    check("wrap_f", srv_f[base], 16'hC21E);
    check("wrap_id", srv_id[base], 1);

    // Backpressure in HOLD with both requesters waiting.
    res_ready = 1'b0;
    rand_req(0);
    for (int i = 0; i < 5 && m_phase != 2; i++) tick();
    check("bp_reached_hold", m_phase, 2);
    rand_req(0);
    rand_req(1);
    repeat (5) tick();
    #1;
    check("bp_readys", {req0_ready, req1_ready}, 2'b00);
    check("bp_ops_held", ops_done, 3);
    res_ready = 1'b1;
    run_ops(3, 20);

    // Fairness under continuous contention.
    do_reset();
    keep[0] = 1'b1;
    keep[1] = 1'b1;
    rand_req(0);
    rand_req(1);
    base = srv_id.size();
    run_ops(6, 40);
    for (int k = 0; k < 6; k++) check("fair_id", srv_id[base+k], k % 2);
    for (int k = 1; k < 6; k++) check("fair_spacing", srv_cyc[base+k] - srv_cyc[base+k-1], 3);
    keep[0] = 1'b0;
    keep[1] = 1'b0;

    // Reset during EXEC discards the result; req1 re-presents.
    do_reset();
    rand_req(1);
    exp_f = ref_f(1);
    tick();
    check("mid_in_exec", m_phase, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_res_valid", res_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_res_f", res_f, 0);
    check("mid_res_id", res_id, 0);
    check("mid_ops_done", ops_done, 0);
    vld[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = srv_id.size();
    run_ops(1, 10);
    check("mid_retry_f", srv_f[base], exp_f);
    check("mid_retry_id", srv_id[base], 1);
    #1;
    check("mid_ops_done_after", ops_done, 1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      for (int id = 0; id < 2; id++) if (!vld[id] && $urandom_range(0, 1) == 1) rand_req(id);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    res_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
